mem_port_arbiter: RTL and testbench

Shares the single 64-bit memory bus between the instruction-cache miss port and the data-cache load/store port. Sits between the two cache controllers and the memory interface. Grants one transaction at a time with round-robin fairness, latches the winner's request, drives the bus, and returns a one-cycle done pulse plus read data to the owner.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the icache/dcache memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RESP      = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_owner_t;

  // Instruction fetches always move a full doubleword.
  localparam logic [2:0] SIZE_DWORD = 3'b011;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side request/response ports and memory-side bus of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);

  // Instruction cache miss port
  logic                  ic_req;
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic                  ic_done;
  logic [DATA_WIDTH-1:0] ic_rdata;

  // Data cache load/store port
  logic                  dc_read_req;
  logic                  dc_write_req;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic [2:0]            dc_size;
  logic                  dc_read_done;
  logic                  dc_write_done;
  logic [DATA_WIDTH-1:0] dc_rdata;

  // Memory bus
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [2:0]            bus_size;
  logic                  bus_ack;
  logic                  bus_resp_valid;
  logic [DATA_WIDTH-1:0] bus_rdata;

  logic                  arb_busy;

  modport slave (
    input  ic_req, ic_addr,
    output ic_done, ic_rdata,
    input  dc_read_req, dc_write_req, dc_addr, dc_wdata, dc_size,
    output dc_read_done, dc_write_done, dc_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_size,
    input  bus_ack, bus_resp_valid, bus_rdata,
    output arb_busy
  );

  modport master (
    output ic_req, ic_addr,
    input  ic_done, ic_rdata,
    output dc_read_req, dc_write_req, dc_addr, dc_wdata, dc_size,
    input  dc_read_done, dc_write_done, dc_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_size,
    output bus_ack, bus_resp_valid, bus_rdata,
    input  arb_busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on contention the requester not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       req_ic_i,
  input  logic       req_dc_i,
  input  arb_owner_t last_grant_i,
  output logic       grant_valid_o,
  output arb_owner_t grant_owner_o
);

  // Combinational winner selection
  always_comb begin
    grant_valid_o = req_ic_i | req_dc_i;
    grant_owner_o = ICACHE;
    if (req_ic_i && req_dc_i) begin
      grant_owner_o = (last_grant_i == ICACHE) ? DCACHE : ICACHE;
    end else if (req_dc_i) begin
      grant_owner_o = DCACHE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the icache miss port and the dcache port.
// One transaction in flight at a time; the winner's request is latched at grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave port
);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  arb_owner_t            last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] ic_rdata_q, ic_rdata_d;
  logic [DATA_WIDTH-1:0] dc_rdata_q, dc_rdata_d;

  logic       dc_req;
  logic       grant_valid;
  arb_owner_t grant_owner;
  logic       capture;

  // A simultaneous dcache read and write is one dcache request; write wins later.
  assign dc_req = port.dc_read_req | port.dc_write_req;

  rr_arb2 u_rr_arb2 (
    .req_ic_i      (port.ic_req),
    .req_dc_i      (dc_req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  // Next-state, grant latching and read-data capture
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    capture      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_owner;
          last_grant_d = grant_owner;
          state_d      = ISSUE;
          if (grant_owner == DCACHE) begin
            we_d    = port.dc_write_req;
            addr_d  = port.dc_addr;
            wdata_d = port.dc_wdata;
            size_d  = port.dc_size;
          end else begin
            we_d    = 1'b0;
            addr_d  = port.ic_addr;
            wdata_d = '0;
            size_d  = SIZE_DWORD;
          end
        end
      end
      ISSUE: begin
        if (port.bus_ack) begin
          if (port.bus_resp_valid) begin
            state_d = RESP;
            capture = 1'b1;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (port.bus_resp_valid) begin
          state_d = RESP;
          capture = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Only reads return data; each port's rdata holds until its next read.
    if (capture && !we_q) begin
      if (owner_q == ICACHE) begin
        ic_rdata_d = port.bus_rdata;
      end else begin
        dc_rdata_d = port.bus_rdata;
      end
    end
  end

  // State, latched request and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= ICACHE;
      last_grant_q <= ICACHE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
    end
  end

  // All outputs come from flops or a state decode.
  assign port.bus_req       = (state_q == ISSUE);
  assign port.bus_we        = we_q;
  assign port.bus_addr      = addr_q;
  assign port.bus_wdata     = wdata_q;
  assign port.bus_size      = size_q;
  assign port.arb_busy      = (state_q != IDLE);
  assign port.ic_done       = (state_q == RESP) && (owner_q == ICACHE);
  assign port.dc_read_done  = (state_q == RESP) && (owner_q == DCACHE) && !we_q;
  assign port.dc_write_done = (state_q == RESP) && (owner_q == DCACHE) && we_q;
  assign port.ic_rdata      = ic_rdata_q;
  assign port.dc_rdata      = dc_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction table plus stall and reset sequences,
// checked against a round-robin reference and a scoreboard queue.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    int          n_ic;
    int          n_dc;
    logic        dr;
    logic        dw;
    logic [63:0] ia;
    logic [63:0] da;
    logic [63:0] wd;
    logic [2:0]  sz;
    int          ack_dly;
    int          resp_dly;
    logic [63:0] rd;
  } vec_t;

  typedef struct {
    logic        is_dc;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    logic [63:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  exp_t       exp_q[$];
  vec_t       vecs[6];
  arb_owner_t m_last;
  int         ic_left, dc_left;
  int         ack_dly, resp_dly;
  int         stall, rcnt, resp_cyc, issue_due;
  logic       pend, req_prev, acked_prev;

  mem_port_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) ifc ();

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .port  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drop_all();
    ifc.ic_req       = 1'b0;
    ifc.dc_read_req  = 1'b0;
    ifc.dc_write_req = 1'b0;
  endtask

  // Monitor and bus responder, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    int   ndone;
    if (!rst_n) begin
      pend = 1'b0; stall = 0; rcnt = 0; req_prev = 1'b0; acked_prev = 1'b0;
      ifc.bus_ack = 1'b0; ifc.bus_resp_valid = 1'b0;
    end else begin
      ndone = int'(ifc.ic_done) + int'(ifc.dc_read_done) + int'(ifc.dc_write_done);
      if (ndone > 1) check("one_hot_done", 64'(ndone), 64'd1);
      if (ndone == 1) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(ndone), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_owner", {63'd0, !ifc.ic_done}, {63'd0, e.is_dc});
          check("done_write", {63'd0, ifc.dc_write_done}, {63'd0, e.we});
          check("done_latency", 64'(cyc), 64'(resp_cyc + 1));
          if (!e.we) check("rdata", e.is_dc ? ifc.dc_rdata : ifc.ic_rdata, e.rdata);
          if (e.is_dc) begin
            dc_left--;
            if (dc_left <= 0) begin ifc.dc_read_req = 1'b0; ifc.dc_write_req = 1'b0; end
          end else begin
            ic_left--;
            if (ic_left <= 0) ifc.ic_req = 1'b0;
          end
          if (ifc.ic_req || ifc.dc_read_req || ifc.dc_write_req) issue_due = cyc + 2;
        end
      end

      if (acked_prev) check("bus_req_fall", {63'd0, ifc.bus_req}, 64'd0);
      if (ifc.bus_req) begin
        if (exp_q.size() == 0) begin
          check("spurious_bus_req", {63'd0, ifc.bus_req}, 64'd0);
        end else if (!req_prev) begin
          check("issue_cycle", 64'(cyc), 64'(issue_due));
          check("bus_we", {63'd0, ifc.bus_we}, {63'd0, exp_q[0].we});
          check("bus_addr", ifc.bus_addr, exp_q[0].addr);
          check("bus_size", {61'd0, ifc.bus_size}, {61'd0, exp_q[0].size});
          if (exp_q[0].we) check("bus_wdata", ifc.bus_wdata, exp_q[0].wdata);
        end else begin
          check("bus_addr_stable", ifc.bus_addr, exp_q[0].addr);
        end
      end

      ifc.bus_ack = 1'b0;
      ifc.bus_resp_valid = 1'b0;
      if (ifc.bus_req) begin
        if (stall >= ack_dly) begin
          ifc.bus_ack = 1'b1;
          stall = 0;
          if (resp_dly == 0) begin
            ifc.bus_resp_valid = 1'b1; resp_cyc = cyc;
          end else begin
            pend = 1'b1; rcnt = 0;
          end
        end else begin
          stall++;
        end
      end else if (pend) begin
        rcnt++;
        if (rcnt >= resp_dly) begin
          ifc.bus_resp_valid = 1'b1; pend = 1'b0; resp_cyc = cyc;
        end
      end
      if (exp_q.size() > 0) ifc.bus_rdata = exp_q[0].rdata;
      req_prev   = ifc.bus_req;
      acked_prev = ifc.bus_ack;
    end
  end

  // Push expected grants in round-robin order, then raise the requests.
  task automatic start_vec(input vec_t v);
    exp_t e;
    int   il, dl, k;
    logic pick_dc;
    ack_dly = v.ack_dly; resp_dly = v.resp_dly;
    il = v.n_ic; dl = v.n_dc; k = 0;
    while (il > 0 || dl > 0) begin
      if (il > 0 && dl > 0) pick_dc = (m_last == ICACHE);
      else                  pick_dc = (dl > 0);
      e.is_dc = pick_dc;
      e.we    = pick_dc && v.dw;
      e.addr  = pick_dc ? v.da : v.ia;
      e.wdata = v.wd;
      e.size  = pick_dc ? v.sz : 3'b011;
      e.rdata = v.rd + 64'(k);
      exp_q.push_back(e);
      if (pick_dc) dl--; else il--;
      m_last = pick_dc ? DCACHE : ICACHE;
      k++;
    end
    ic_left = v.n_ic; dc_left = v.n_dc;
    @(posedge clk); #2;
    ifc.ic_addr  = v.ia;
    ifc.dc_addr  = v.da;
    ifc.dc_wdata = v.wd;
    ifc.dc_size  = v.sz;
    ifc.ic_req       = (v.n_ic > 0);
    ifc.dc_read_req  = (v.n_dc > 0) && v.dr;
    ifc.dc_write_req = (v.n_dc > 0) && v.dw;
    issue_due = cyc + 1;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      drop_all();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    vec_t vs;
    n_checks = 0; n_fail = 0; cyc = 0;
    m_last = ICACHE; ic_left = 0; dc_left = 0;
    ack_dly = 0; resp_dly = 0; stall = 0; rcnt = 0; resp_cyc = -10; issue_due = 0;
    pend = 1'b0; req_prev = 1'b0; acked_prev = 1'b0;
    rst_n = 1'b0;
    drop_all();
    ifc.ic_addr = '0; ifc.dc_addr = '0; ifc.dc_wdata = '0; ifc.dc_size = '0;
    ifc.bus_ack = 1'b0; ifc.bus_resp_valid = 1'b0; ifc.bus_rdata = '0;

    // contended write + icache read, six alternating reads, lone dcache read,
    // icache ack+resp same cycle, read+write collapse to write, slow icache
    vecs[0] = '{n_ic:1, n_dc:1, dr:0, dw:1, ia:64'h40, da:64'h80, wd:64'h1122334455667788,
                sz:3'b010, ack_dly:1, resp_dly:1, rd:64'h0};
    vecs[1] = '{n_ic:3, n_dc:3, dr:1, dw:0, ia:64'h100, da:64'h200, wd:64'h0,
                sz:3'b011, ack_dly:0, resp_dly:1, rd:64'hA0};
    vecs[2] = '{n_ic:0, n_dc:1, dr:1, dw:0, ia:64'h0, da:64'h1000, wd:64'h0,
                sz:3'b011, ack_dly:0, resp_dly:2, rd:64'hDEADBEEF};
    vecs[3] = '{n_ic:1, n_dc:0, dr:0, dw:0, ia:64'h8000, da:64'h0, wd:64'h0,
                sz:3'b000, ack_dly:0, resp_dly:0, rd:64'hCAFEF00D};
    vecs[4] = '{n_ic:0, n_dc:1, dr:1, dw:1, ia:64'h0, da:64'h4000, wd:64'h55AA,
                sz:3'b001, ack_dly:2, resp_dly:0, rd:64'h0};
    vecs[5] = '{n_ic:1, n_dc:0, dr:0, dw:0, ia:64'h10, da:64'h0, wd:64'h0,
                sz:3'b000, ack_dly:3, resp_dly:3, rd:64'h1234};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", {63'd0, ifc.bus_req}, 64'd0);
    check("rst_arb_busy", {63'd0, ifc.arb_busy}, 64'd0);
    check("rst_dones", {61'd0, ifc.ic_done, ifc.dc_read_done, ifc.dc_write_done}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      start_vec(vecs[i]);
      wait_empty(300);
    end

    // Ack stall of five cycles while the dcache address moves underneath.
    vs = '{n_ic:0, n_dc:1, dr:1, dw:0, ia:64'h0, da:64'h1000, wd:64'h0,
           sz:3'b000, ack_dly:5, resp_dly:1, rd:64'h77};
    start_vec(vs);
    repeat (3) @(posedge clk);
    #2 ifc.dc_addr = 64'h2000;
    wait_empty(300);

    // Reset in WAIT_RESP abandons the read; no done may follow.
    vs = '{n_ic:0, n_dc:1, dr:1, dw:0, ia:64'h0, da:64'h3000, wd:64'h0,
           sz:3'b011, ack_dly:0, resp_dly:20, rd:64'h99};
    start_vec(vs);
    repeat (4) @(posedge clk);
    #2;
    check("busy_before_rst", {63'd0, ifc.arb_busy}, 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    drop_all();
    m_last = ICACHE;
    #1;
    check("arst_busy", {63'd0, ifc.arb_busy}, 64'd0);
    check("arst_bus_req", {63'd0, ifc.bus_req}, 64'd0);
    check("arst_bus_addr", ifc.bus_addr, 64'd0);
    check("arst_bus_ctl", {60'd0, ifc.bus_we, ifc.bus_size}, 64'd0);
    check("arst_dc_rdata", ifc.dc_rdata, 64'd0);
    check("arst_ic_rdata", ifc.ic_rdata, 64'd0);
    @(negedge clk);
    check("arst_dones", {61'd0, ifc.ic_done, ifc.dc_read_done, ifc.dc_write_done}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("idle_after_rst", {63'd0, ifc.arb_busy}, 64'd0);

    // Contended request after reset must grant dcache first.
    start_vec(vecs[0]);
    wait_empty(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
